// File: rtl/byte_serial_subtractor.sv
// Slice-serial WIDTH-bit subtractor (A + ~B + 1), one SLICE-bit slice per cycle from the LSB.
// Produces the difference, borrow and compare/branch flags, all valid from the DONE cycle.
module byte_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o,
  output logic             z_o,
  output logic             n_o,
  output logic             v_o,
  output logic             lt_o,
  output logic             ltu_o
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             bout_q, bout_d, z_q, z_d, n_q, n_d, v_q, v_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sum;

  assign a_sl = a_q[idx_q*SLICE +: SLICE];
  assign b_sl = b_q[idx_q*SLICE +: SLICE];
  // The registered carry is the only path between slices.
  assign sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, c_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    bout_d  = bout_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        d_d[idx_q*SLICE +: SLICE] = sum[SLICE-1:0];
        c_d   = sum[SLICE];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // Flags see the complete result including the slice written this cycle.
          idx_d   = '0;
          state_d = S_FIN;
          bout_d  = ~sum[SLICE];
          z_d     = (d_d == '0);
          n_d     = d_d[WIDTH-1];
          v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIN);
  assign d_o    = d_q;
  assign bout_o = bout_q;
  assign z_o    = z_q;
  assign n_o    = n_q;
  assign v_o    = v_q;
  assign lt_o   = n_q ^ v_q;
  assign ltu_o  = bout_q;

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Directed table-driven bench for byte_serial_subtractor plus hand-written
// sequences for ignored START and mid-operation reset.
module tb_byte_serial_subtractor;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [31:0] a_i, b_i, d_o;
  logic        busy_o, done_o, bout_o, z_o, n_o, v_o, lt_o, ltu_o;

  int checks = 0;
  int errors = 0;

  byte_serial_subtractor #(.WIDTH(32), .SLICE(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .d_o(d_o), .bout_o(bout_o), .z_o(z_o),
    .n_o(n_o), .v_o(v_o), .lt_o(lt_o), .ltu_o(ltu_o)
  );

  always #5 clk_i = ~clk_i;

  // flags packed as {bout, z, n, v, lt, ltu}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [5:0]  fl;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [5:0] flags();
    return {bout_o, z_o, n_o, v_o, lt_o, ltu_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of the DONE cycle.
  // With glitch=1, a second START with different operands is pulsed in cycle 2.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit glitch,
                        input logic [31:0] exp_d, input logic [5:0] exp_fl, input string name);
    int cyc;
    start_i = 1'b1; a_i = a; b_i = b;
    @(negedge clk_i);
    cyc = 1;
    start_i = 1'b0; a_i = ~a; b_i = b ^ 32'h5a5a_5a5a;
    chk({name, " busy c1"}, {31'd0, busy_o}, 32'd1);
    while (!done_o && cyc < 20) begin
      start_i = glitch && (cyc == 2);
      if (glitch && cyc == 2) begin a_i = 32'd1; b_i = 32'd2; end
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
    end
    chk({name, " done cycle"}, cyc, 5);
    chk({name, " busy@done"}, {31'd0, busy_o}, 32'd1);
    chk({name, " D"}, d_o, exp_d);
    chk({name, " flags"}, {26'd0, flags()}, {26'd0, exp_fl});
  endtask

  // One cycle after DONE: pulse gone, idle, results held.
  task automatic post_done(input logic [31:0] exp_d, input logic [5:0] exp_fl, input string name);
    @(negedge clk_i);
    chk({name, " done width"}, {31'd0, done_o}, 32'd0);
    chk({name, " busy idle"}, {31'd0, busy_o}, 32'd0);
    chk({name, " D held"}, d_o, exp_d);
    chk({name, " flags held"}, {26'd0, flags()}, {26'd0, exp_fl});
  endtask

  initial begin
    int seen_done;
    vecs[0] = '{32'd5,         32'd3,         32'h0000_0002, 6'b000000};
    vecs[1] = '{32'd3,         32'd5,         32'hFFFF_FFFE, 6'b101011};
    vecs[2] = '{32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 6'b000110};
    vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 6'b101101};
    vecs[4] = '{32'h0100_0000, 32'd1,         32'h00FF_FFFF, 6'b000000};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 6'b010000};
    vecs[6] = '{32'd0,         32'd1,         32'hFFFF_FFFF, 6'b101011};
    vecs[7] = '{32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 6'b001010};

    rst_i = 1'b1; start_i = 1'b1; a_i = 32'd7; b_i = 32'd1;
    repeat (3) @(negedge clk_i);
    chk("reset D", d_o, 32'd0);
    chk("reset flags", {26'd0, flags()}, 32'd0);
    chk("reset busy/done", {30'd0, busy_o, done_o}, 32'd0);
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].d, vecs[i].fl, $sformatf("vec%0d", i));
      post_done(vecs[i].d, vecs[i].fl, $sformatf("vec%0d", i));
    end

    // START during BUSY is ignored; the next START in cycle 6 is accepted.
    run_op(32'd9, 32'd4, 1'b1, 32'd5, 6'b000000, "ignore");
    post_done(32'd5, 6'b000000, "ignore");
    run_op(32'd20, 32'd7, 1'b0, 32'd13, 6'b000000, "after-ignore");
    post_done(32'd13, 6'b000000, "after-ignore");

    // Reset in cycle 2 aborts: outputs zero, no DONE.
    start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    chk("abort busy", {31'd0, busy_o}, 32'd0);
    chk("abort D", d_o, 32'd0);
    chk("abort flags", {26'd0, flags()}, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_o) seen_done++;
      @(negedge clk_i);
    end
    chk("abort no done", seen_done, 0);
    run_op(32'd10, 32'd10, 1'b0, 32'd0, 6'b010000, "post-abort");
    post_done(32'd0, 6'b010000, "post-abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
